// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory port and the writeback-side load aligner.
package lsu_pkg;

  // RISC-V load/store funct3 encodings (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  // Width of the REQ+RESP cycle counter; bounds the usable timeout to 255
  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_port_state_t;

  // Number of bytes touched by an access with the given funct3
  function automatic logic [3:0] access_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_align.sv
// Combinational load aligner: shifts the addressed lanes down and sign/zero-extends.
module load_align
  import lsu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] rdata_i,
  input  logic [2:0]   byte_off_i,
  input  logic [2:0]   funct3_i,
  output logic [N-1:0] result_o
);

  logic [N-1:0] shifted;

  assign shifted = rdata_i >> {byte_off_i, 3'b000};

  // Pick the access width and extension kind from funct3
  always_comb begin
    result_o = shifted;
    case (funct3_i)
      F3_LB:   result_o = {{(N-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  result_o = {{(N-8){1'b0}}, shifted[7:0]};
      F3_LH:   result_o = {{(N-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  result_o = {{(N-16){1'b0}}, shifted[15:0]};
      F3_LW:   result_o = {{(N-32){shifted[31]}}, shifted[31:0]};
      F3_LWU:  result_o = {{(N-32){1'b0}}, shifted[31:0]};
      F3_LD:   result_o = shifted;
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Bus-side stage behind the LSU: runs one request/response transaction per
// operation, stalls the pipeline meanwhile and reports errors/timeouts as faults.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int N       = 64,
  parameter int BYTES   = N / 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_load,
  input  logic [2:0]       funct3,
  input  logic [N-1:0]     addr,
  input  logic [N-1:0]     wdata,
  input  logic [BYTES-1:0] wmask,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     load_result,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  output logic [BYTES-1:0] mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [N-1:0]     mem_rdata,
  input  logic             mem_err
);

  lsu_port_state_t      state_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic                 isLoad_q;
  logic [2:0]           funct3_q;
  logic [2:0]           byteOff_q;
  logic [N-1:0]         addr_q;
  logic [N-1:0]         wdata_q;
  logic [BYTES-1:0]     be_q;
  logic [N-1:0]         result_q;
  logic                 fault_q;

  logic [N-1:0]         alignedLoad;
  logic                 respNow;
  logic                 timeoutHit;

  load_align #(.N(N)) u_align (
    .rdata_i    (mem_rdata),
    .byte_off_i (byteOff_q),
    .funct3_i   (funct3_q),
    .result_o   (alignedLoad)
  );

  assign cnt_d      = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign timeoutHit = (cnt_d == TIMEOUT_W'(TIMEOUT));

  // A grant that arrives together with rvalid already counts as the response
  assign respNow = ((state_q == REQ) && mem_gnt && mem_rvalid) ||
                   ((state_q == RESP) && mem_rvalid);

  // Transaction FSM together with the capture, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isLoad_q  <= 1'b0;
      funct3_q  <= '0;
      byteOff_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      result_q  <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            isLoad_q  <= is_load;
            funct3_q  <= funct3;
            byteOff_q <= addr[2:0];
            addr_q    <= {addr[N-1:3], 3'b000};
            wdata_q   <= wdata;
            be_q      <= is_load ? {BYTES{1'b1}} : wmask;
            cnt_q     <= '0;
            if (is_load && (funct3 == F3_ILLEGAL)) begin
              state_q  <= DONE;
              fault_q  <= 1'b1;
              result_q <= '0;
            end else begin
              state_q <= REQ;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        REQ, RESP: begin
          cnt_q <= cnt_d;
          if (respNow) begin
            state_q  <= DONE;
            fault_q  <= mem_err;
            result_q <= (mem_err || !isLoad_q) ? '0 : alignedLoad;
          end else if (timeoutHit) begin
            state_q  <= DONE;
            fault_q  <= 1'b1;
            result_q <= '0;
          end else if ((state_q == REQ) && mem_gnt) begin
            state_q <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == REQ) || (state_q == RESP);
  assign done        = (state_q == DONE);
  assign fault       = fault_q;
  assign load_result = result_q;
  assign mem_req     = (state_q == REQ);
  assign mem_we      = (state_q == REQ) && !isLoad_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed transactions push expected
// completions; a negedge monitor pops and compares whenever done is seen.
module tb_lsu_mem_port;

  localparam int N     = 64;
  localparam int BYTES = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             is_load;
  logic [2:0]       funct3;
  logic [N-1:0]     addr;
  logic [N-1:0]     wdata;
  logic [BYTES-1:0] wmask;
  logic             busy, done, fault, mem_req, mem_we;
  logic [N-1:0]     load_result, mem_addr, mem_wdata;
  logic [BYTES-1:0] mem_be;
  logic             mem_gnt, mem_rvalid, mem_err;
  logic [N-1:0]     mem_rdata;

  logic             toStart;
  logic             toBusy, toDone, toFault, toMemReq, toMemWe;
  logic [N-1:0]     toResult, toMemAddr, toMemWdata;
  logic [BYTES-1:0] toMemBe;
  logic             toGnt, toRvalid, toErr;
  logic [N-1:0]     toRdata;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCnt    = 0;

  typedef struct {
    logic [63:0] result;
    logic        fault;
    int          doneCycle;
    string       name;
  } exp_t;

  exp_t sbMain[$];
  exp_t sbTo[$];

  always #5 clk = ~clk;

  // Cycle index: advances on every rising edge
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  lsu_mem_port dut (
    .clk (clk), .rst_n (rst_n), .start (start), .is_load (is_load),
    .funct3 (funct3), .addr (addr), .wdata (wdata), .wmask (wmask),
    .busy (busy), .done (done), .load_result (load_result), .fault (fault),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_be (mem_be), .mem_gnt (mem_gnt),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata), .mem_err (mem_err)
  );

  lsu_mem_port #(.TIMEOUT(4)) dutTo (
    .clk (clk), .rst_n (rst_n), .start (toStart), .is_load (is_load),
    .funct3 (funct3), .addr (addr), .wdata (wdata), .wmask (wmask),
    .busy (toBusy), .done (toDone), .load_result (toResult), .fault (toFault),
    .mem_req (toMemReq), .mem_we (toMemWe), .mem_addr (toMemAddr),
    .mem_wdata (toMemWdata), .mem_be (toMemBe), .mem_gnt (toGnt),
    .mem_rvalid (toRvalid), .mem_rdata (toRdata), .mem_err (toErr)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sbMain.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL spurious done: got done=1 at cycle %0d, expected no completion", cycleCnt);
      end else begin
        e = sbMain.pop_front();
        checkOutput({e.name, " load_result"}, load_result, e.result);
        checkOutput({e.name, " fault"}, 64'(fault), 64'(e.fault));
        checkOutput({e.name, " done cycle"}, 64'(cycleCnt), 64'(e.doneCycle));
      end
    end
    if (toDone === 1'b1) begin
      if (sbTo.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL spurious timeout done: got done=1 at cycle %0d, expected none", cycleCnt);
      end else begin
        e = sbTo.pop_front();
        checkOutput({e.name, " load_result"}, toResult, e.result);
        checkOutput({e.name, " fault"}, 64'(toFault), 64'(e.fault));
        checkOutput({e.name, " done cycle"}, 64'(cycleCnt), 64'(e.doneCycle));
      end
    end
  end

  // One full transaction on the main DUT with a scripted bus response
  task automatic applyStimulus(
    input string       name,
    input logic        isLoadV,
    input logic [2:0]  f3,
    input logic [63:0] a,
    input logic [63:0] wd,
    input logic [7:0]  wm,
    input int          gntDelay,
    input int          rvDelay,
    input logic        sameCycle,
    input logic        spurious,
    input logic [63:0] rd,
    input logic        err,
    input logic [63:0] expRes,
    input logic        expFault,
    input int          expLat
  );
    logic [63:0] alignedA;
    alignedA = a & ~64'h7;
    is_load = isLoadV;
    funct3  = f3;
    addr    = a;
    wdata   = wd;
    wmask   = wm;
    start   = 1'b1;
    sbMain.push_back('{expRes, expFault, cycleCnt + expLat, name});
    @(posedge clk) #1;
    start = 1'b0;
    if (isLoadV && (f3 == 3'b111)) begin
      checkOutput({name, " mem_req"}, 64'(mem_req), 64'd0);
      checkOutput({name, " busy"}, 64'(busy), 64'd0);
      @(posedge clk) #1;
    end else begin
      checkOutput({name, " req mem_req"}, 64'(mem_req), 64'd1);
      checkOutput({name, " req mem_we"}, 64'(mem_we), 64'(!isLoadV));
      checkOutput({name, " req mem_addr"}, mem_addr, alignedA);
      checkOutput({name, " req mem_be"}, 64'(mem_be), isLoadV ? 64'hFF : 64'(wm));
      checkOutput({name, " req mem_wdata"}, mem_wdata, wd);
      checkOutput({name, " req busy"}, 64'(busy), 64'd1);
      for (int i = 0; i < gntDelay; i++) begin
        mem_gnt = 1'b0;
        if (spurious && (i == 0)) begin
          start   = 1'b1;
          addr    = a ^ 64'h100;
          is_load = !isLoadV;
        end
        @(posedge clk) #1;
        start   = 1'b0;
        addr    = a;
        is_load = isLoadV;
        checkOutput({name, " stall mem_req"}, 64'(mem_req), 64'd1);
        checkOutput({name, " stall mem_addr"}, mem_addr, alignedA);
      end
      mem_gnt = 1'b1;
      if (sameCycle) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        mem_err    = err;
      end
      @(posedge clk) #1;
      mem_gnt = 1'b0;
      if (!sameCycle) begin
        checkOutput({name, " resp mem_req"}, 64'(mem_req), 64'd0);
        checkOutput({name, " resp busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < rvDelay; i++) @(posedge clk) #1;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        mem_err    = err;
        @(posedge clk) #1;
      end
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      checkOutput({name, " done busy"}, 64'(busy), 64'd0);
      @(posedge clk) #1;
    end
    checkOutput({name, " idle done"}, 64'(done), 64'd0);
    checkOutput({name, " held load_result"}, load_result, expRes);
  endtask

  // Stimulus sequence
  initial begin
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; funct3 = 3'b0;
    addr = '0; wdata = '0; wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    toStart = 1'b0; toGnt = 1'b0; toRvalid = 1'b0; toRdata = '0; toErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset mem_addr", mem_addr, 64'd0);
    checkOutput("reset mem_be", 64'(mem_be), 64'd0);
    checkOutput("reset load_result", load_result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    //             name          ld  f3      addr         wdata                  wm     g  r  sc sp rdata                  err  expected               flt lat
    applyStimulus("SW",          0, 3'b010, 64'h3004, 64'hDEADBEEF_00000000, 8'hF0, 0, 0, 0, 0, 64'h0,                 0, 64'h0,                  0, 3);
    applyStimulus("LB",          1, 3'b000, 64'h1003, 64'h0, 8'h00, 0, 0, 0, 0, 64'h00000000_80000000, 0, 64'hFFFFFFFF_FFFFFF80, 0, 3);
    applyStimulus("LBU",         1, 3'b100, 64'h1003, 64'h0, 8'h00, 0, 0, 0, 0, 64'h00000000_80000000, 0, 64'h00000000_00000080, 0, 3);
    applyStimulus("LWU",         1, 3'b110, 64'h6004, 64'h0, 8'h00, 1, 1, 0, 0, 64'hF2345678_00000000, 0, 64'h00000000_F2345678, 0, 5);
    applyStimulus("LW",          1, 3'b010, 64'h6004, 64'h0, 8'h00, 0, 0, 0, 0, 64'hF2345678_00000000, 0, 64'hFFFFFFFF_F2345678, 0, 3);
    applyStimulus("LH",          1, 3'b001, 64'h2006, 64'h0, 8'h00, 0, 0, 0, 0, 64'h8001_0000_0000_0000, 0, 64'hFFFFFFFF_FFFF8001, 0, 3);
    applyStimulus("LHU",         1, 3'b101, 64'h2006, 64'h0, 8'h00, 0, 2, 0, 0, 64'h8001_0000_0000_0000, 0, 64'h00000000_00008001, 0, 5);
    applyStimulus("LD",          1, 3'b011, 64'h4000, 64'h0, 8'h00, 0, 0, 0, 0, 64'h01234567_89ABCDEF, 0, 64'h01234567_89ABCDEF, 0, 3);
    applyStimulus("gnt stall",   1, 3'b011, 64'h5000, 64'h0, 8'h00, 3, 0, 0, 1, 64'h11223344_55667788, 0, 64'h11223344_55667788, 0, 6);
    applyStimulus("gnt+rvalid",  1, 3'b100, 64'h7001, 64'h0, 8'h00, 0, 0, 1, 0, 64'h00000000_0000AB00, 0, 64'h00000000_000000AB, 0, 2);
    applyStimulus("SD slow ack", 0, 3'b011, 64'h8008, 64'h01020304_05060708, 8'hFF, 0, 2, 0, 0, 64'hFFFF0000_FFFF0000, 0, 64'h0, 0, 5);
    applyStimulus("bus err",     1, 3'b010, 64'h8000, 64'h0, 8'h00, 0, 0, 0, 0, 64'hFFFFFFFF_FFFFFFFF, 1, 64'h0,                  1, 3);
    applyStimulus("LD again",    1, 3'b011, 64'h9000, 64'h0, 8'h00, 0, 0, 0, 0, 64'hCAFEF00D_12345678, 0, 64'hCAFEF00D_12345678, 0, 3);
    applyStimulus("illegal f3",  1, 3'b111, 64'hB000, 64'h0, 8'h00, 0, 0, 0, 0, 64'h0,                 0, 64'h0,                  1, 1);

    // Timeout on the TIMEOUT=4 instance: no grant ever
    is_load = 1'b1; funct3 = 3'b011; addr = 64'hA000;
    toStart = 1'b1;
    sbTo.push_back('{64'h0, 1'b1, cycleCnt + 5, "timeout"});
    @(posedge clk) #1;
    toStart = 1'b0;
    checkOutput("timeout mem_req raised", 64'(toMemReq), 64'd1);
    repeat (3) begin
      @(posedge clk) #1;
      checkOutput("timeout busy", 64'(toBusy), 64'd1);
    end
    @(posedge clk) #1;
    checkOutput("timeout mem_req dropped", 64'(toMemReq), 64'd0);
    checkOutput("timeout busy dropped", 64'(toBusy), 64'd0);
    @(posedge clk) #1;

    // Reset in the middle of RESP, then a stray rvalid
    is_load = 1'b1; funct3 = 3'b011; addr = 64'hC008; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk) #1;
    mem_gnt = 1'b0;
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 64'(busy), 64'd0);
    checkOutput("async reset done", 64'(done), 64'd0);
    checkOutput("async reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("async reset mem_we", 64'(mem_we), 64'd0);
    checkOutput("async reset mem_addr", mem_addr, 64'd0);
    checkOutput("async reset mem_wdata", mem_wdata, 64'd0);
    checkOutput("async reset mem_be", 64'(mem_be), 64'd0);
    checkOutput("async reset load_result", load_result, 64'd0);
    checkOutput("async reset fault", 64'(fault), 64'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk) #1;
    mem_rvalid = 1'b0;
    checkOutput("post-reset busy", 64'(busy), 64'd0);
    checkOutput("post-reset done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("main scoreboard drained", 64'(sbMain.size()), 64'd0);
    checkOutput("timeout scoreboard drained", 64'(sbTo.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Sequential bus-side stage placed directly downstream of the combinational LSU in the RV64 core.
- Takes the LSU's address, write data and byte mask, and runs one request/response transaction on the data-memory bus.
- For loads, aligns and sign/zero-extends the returned doubleword according to funct3.
- Stalls the pipeline while a transaction is in flight, and reports bus errors and timeouts as access faults.

Parameters:
- N, 64, data/address width.
- BYTES, N/8, byte lanes per bus word.
- TIMEOUT, 255, maximum cycles spent in REQ+RESP before a fault; legal range 1..255, counter is 8 bits.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  operation valid: LSU load|store with exc_valid=0.
- is_load  in  1  1=load, 0=store.
- funct3  in  3  RISC-V access size/sign field.
- addr  in  N  byte address (the LSU's mem_address).
- wdata  in  N  lane-positioned store data (the LSU's mem_writeData).
- wmask  in  BYTES  store byte mask (the LSU's mem_writeMask).
- busy  out  1  pipeline stall.
- done  out  1  one-cycle completion pulse.
- load_result  out  N  extended load value; valid when done=1.
- fault  out  1  access fault qualifier; valid when done=1.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  N  bus address, {addr[N-1:3],3'b000}.
- mem_wdata  out  N  bus write data.
- mem_be  out  BYTES  byte enables: wmask for stores, all-ones for loads.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response or write acknowledge.
- mem_rdata  in  N  read data.
- mem_err  in  1  bus error, qualified by mem_rvalid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; timeout counter and all capture registers clear.
  - Every output is 0, including mem_addr, mem_be and load_result.
  - Reset in the middle of a transaction drops mem_req immediately; no done pulse is produced.
- States: IDLE, REQ, RESP, DONE.
- IDLE / DONE:
  - start=1 captures is_load, funct3, addr, wdata and wmask, and clears the counter.
  - Next state is REQ.
  - Exception: is_load=1 with funct3=111 goes straight to DONE with fault=1 and no bus access.
  - start=0 goes to or stays in IDLE.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_be are driven from the capture registers and held stable until granted.
  - mem_gnt=1 goes to RESP.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle is treated as a completed response and goes to DONE.
- RESP:
  - mem_req=0.
  - mem_rvalid=1 registers the result and goes to DONE.
  - A store also waits for mem_rvalid (write acknowledge); its load_result is 0.
- DONE:
  - done=1 for exactly one cycle.
  - fault = mem_err, or timeout, or illegal funct3.
  - load_result is held until the next done.
- Timeout:
  - The counter increments on every cycle spent in REQ or RESP.
  - When it reaches TIMEOUT: drop mem_req, go to DONE with fault=1 and load_result=0.
- busy=1 in REQ and RESP; busy=0 in IDLE and DONE.
- start is ignored while busy=1.
- mem_rvalid and mem_gnt are ignored in IDLE and DONE. Bus contract: the bus gives no response after a timeout.
- Minimum latency:
  - start sampled at cycle 0, REQ at cycle 1.
  - With mem_gnt at 1 and mem_rvalid at 2, done is high at cycle 3.
- Load extraction:
  - sh = mem_rdata >> (8*addr[2:0]).
  - 000 LB → sext sh[7:0]; 100 LBU → zext sh[7:0].
  - 001 LH → sext sh[15:0]; 101 LHU → zext sh[15:0].
  - 010 LW → sext sh[31:0]; 110 LWU → zext sh[31:0].
  - 011 LD → sh.
  - Alignment is guaranteed upstream.
- On mem_err or timeout, load_result=0.

Decomposition:
- Shared package lsu_pkg holds:
  - the funct3 constants F3_LB..F3_LWU;
  - the state enum lsu_port_state_t {IDLE,REQ,RESP,DONE};
  - the access-size helper function;
  - the TIMEOUT counter width constant.
- One sub-module, load_align: purely combinational (rdata, byte_off, funct3) → extended result; reused by the writeback stage.

Test Plan:
1. Store SW, addr=0x3004, wdata=0xDEADBEEF_00000000, wmask=0xF0; gnt at cycle 1, rvalid at cycle 2 → cycle 1 shows mem_req=1, mem_we=1, mem_addr=0x3000, mem_be=0xF0; done at cycle 3 with fault=0; busy=1 at cycles 1–2.
2. Load LB, addr=0x1003, rdata=0x00000000_80000000 → load_result=0xFFFFFFFF_FFFFFF80. Load LBU with the same stimulus → load_result=0x80.
3. Load LWU, addr=0x6004, rdata=0xF234_5678_0000_0000 → load_result=0x0000_0000_F234_5678. Load LW with the same stimulus → load_result=0xFFFF_FFFF_F234_5678.
4. mem_gnt held low for 3 cycles → mem_req and mem_addr stay stable; done follows 2 cycles after the grant. A second start pulsed while busy=1 is ignored: only one transaction occurs.
5. mem_rvalid with mem_err=1 → done=1, fault=1, load_result=0. With TIMEOUT=4 and no gnt → mem_req drops and done with fault=1 arrives 5 cycles after start.
6. rst_n driven low while in RESP → all outputs 0 immediately; a mem_rvalid arriving afterwards is ignored. A load with funct3=111 → done at cycle 1, fault=1, mem_req never asserted.
